// File: rtl/e603_subsys_irq_router.sv
// e603_subsys_irq_router
// Interrupt router/conditioner between the E603 peripheral interrupt sources
// and the core's external interrupt vector. Every source is synchronised into
// clk, optionally converted into a sticky rising-edge pending bit, gated by a
// per-source enable, and placed at its primary slot plus an optional mirror
// slot of a registered output vector.
module e603_subsys_irq_router #(
  parameter int SRC_NUM     = 9,
  parameter int OUT_NUM     = 51,
  parameter int SYNC_STAGES = 2,
  parameter int MIRROR_BASE = 32,
  parameter int MIRROR_NUM  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic [SRC_NUM-1:0] src_en,
  input  logic [SRC_NUM-1:0] src_edge,
  input  logic [SRC_NUM-1:0] pend_clr,
  output logic [SRC_NUM-1:0] pend_o,
  output logic [OUT_NUM-1:0] irq_out
);

  // Reject illegal configurations at elaboration time.
  if (SRC_NUM < 1 || SRC_NUM > 32) begin : g_bad_src_num
    $error("e603_subsys_irq_router: SRC_NUM must be in 1..32");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("e603_subsys_irq_router: SYNC_STAGES must be in 1..3");
  end
  if (MIRROR_NUM < 0 || MIRROR_BASE < 0) begin : g_bad_neg
    $error("e603_subsys_irq_router: MIRROR_NUM and MIRROR_BASE must be non-negative");
  end
  if (SRC_NUM > MIRROR_BASE) begin : g_bad_base
    $error("e603_subsys_irq_router: SRC_NUM must not exceed MIRROR_BASE");
  end
  if (MIRROR_NUM > SRC_NUM) begin : g_bad_mnum
    $error("e603_subsys_irq_router: MIRROR_NUM must not exceed SRC_NUM");
  end
  if (MIRROR_BASE + MIRROR_NUM > OUT_NUM) begin : g_bad_out
    $error("e603_subsys_irq_router: mirror region exceeds OUT_NUM");
  end

  logic [SRC_NUM-1:0] r_sync [SYNC_STAGES];
  logic [SRC_NUM-1:0] r_prev;
  logic [SRC_NUM-1:0] r_pend;
  logic [OUT_NUM-1:0] r_irq_out;

  logic [SRC_NUM-1:0] w_s;
  logic [SRC_NUM-1:0] w_rise;
  logic [SRC_NUM-1:0] w_pend_nxt;
  logic [SRC_NUM-1:0] w_v;
  logic [OUT_NUM-1:0] w_irq_nxt;

  // ---- stage boundary: raw sources -> synchronised s[] ----
  // Synchroniser chain; the last stage is the clean source value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        r_sync[st] <= '0;
      end
    end else begin
      r_sync[0] <= src_irq;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        r_sync[st] <= r_sync[st-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ---- stage boundary: s[] -> previous value p[] and pending ----
  // Rise detect and pending next state. Set beats clear; a disabled or
  // level-mode source never keeps a pending event.
  always_comb begin
    w_rise     = w_s & ~r_prev;
    w_pend_nxt = src_en & src_edge & (w_rise | (r_pend & ~pend_clr));
  end

  // Previous-value flop for rise detection and the sticky pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
    end
  end

  // ---- stage boundary: pending/level value -> registered output vector ----
  // Select per-source value and place it at its primary and mirror slots;
  // every other output bit is a hard zero.
  always_comb begin
    w_v       = src_en & ((src_edge & r_pend) | (~src_edge & w_s));
    w_irq_nxt = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      w_irq_nxt[i] = w_v[i];
    end
    for (int k = 0; k < MIRROR_NUM; k++) begin
      w_irq_nxt[MIRROR_BASE + k] = w_v[k];
    end
  end

  // Output register towards the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_out <= '0;
    end else begin
      r_irq_out <= w_irq_nxt;
    end
  end

  assign pend_o  = r_pend;
  assign irq_out = r_irq_out;

endmodule

// File: tb/tb_e603_subsys_irq_router.sv
// Testbench for e603_subsys_irq_router: default configuration plus a second
// instance with a reduced parameter set (4 sources, 3 sync stages).
module tb_e603_subsys_irq_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [8:0]  src_irq, src_en, src_edge, pend_clr;
  logic [8:0]  pend_o;
  logic [50:0] irq_out;

  logic [3:0]  s4_irq, s4_en, s4_edge, s4_clr;
  logic [3:0]  s4_pend;
  logic [15:0] s4_out;

  int n_chk = 0;
  int n_err = 0;

  e603_subsys_irq_router dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .src_en(src_en),
    .src_edge(src_edge), .pend_clr(pend_clr), .pend_o(pend_o), .irq_out(irq_out)
  );

  e603_subsys_irq_router #(
    .SRC_NUM(4), .OUT_NUM(16), .SYNC_STAGES(3), .MIRROR_BASE(8), .MIRROR_NUM(2)
  ) dut4 (
    .clk(clk), .rst(rst), .src_irq(s4_irq), .src_en(s4_en),
    .src_edge(s4_edge), .pend_clr(s4_clr), .pend_o(s4_pend), .irq_out(s4_out)
  );

  typedef struct {
    logic [8:0]  irq;
    logic [8:0]  en;
    logic [8:0]  edg;
    logic [8:0]  clr;
    logic [8:0]  exp_pend;
    logic [50:0] exp_out;
  } vec_t;

  vec_t tbl [18];

  localparam logic [50:0] L2   = 51'h4_0000_0004;
  localparam logic [50:0] FULL = 51'h7F_0000_01FF;

  function automatic vec_t mk(input logic [8:0] irq, input logic [8:0] en,
                              input logic [8:0] edg, input logic [8:0] clr,
                              input logic [8:0] ep, input logic [50:0] eo);
    vec_t v;
    v.irq = irq; v.en = en; v.edg = edg; v.clr = clr;
    v.exp_pend = ep; v.exp_out = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Level mode on source 2: 5 high, 5 low, then same waveform disabled.
    tbl[0]  = mk(9'h004, 9'h1FF, 9'h000, 9'h000, 9'h000, '0);
    tbl[1]  = mk(9'h004, 9'h1FF, 9'h000, 9'h000, 9'h000, '0);
    tbl[2]  = mk(9'h004, 9'h1FF, 9'h000, 9'h000, 9'h000, L2);
    tbl[3]  = mk(9'h004, 9'h1FF, 9'h000, 9'h000, 9'h000, L2);
    tbl[4]  = mk(9'h004, 9'h1FF, 9'h000, 9'h000, 9'h000, L2);
    tbl[5]  = mk(9'h000, 9'h1FF, 9'h000, 9'h000, 9'h000, L2);
    tbl[6]  = mk(9'h000, 9'h1FF, 9'h000, 9'h000, 9'h000, L2);
    tbl[7]  = mk(9'h000, 9'h1FF, 9'h000, 9'h000, 9'h000, '0);
    tbl[8]  = mk(9'h000, 9'h1FF, 9'h000, 9'h000, 9'h000, '0);
    tbl[9]  = mk(9'h000, 9'h1FF, 9'h000, 9'h000, 9'h000, '0);
    tbl[10] = mk(9'h004, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[11] = mk(9'h004, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[12] = mk(9'h004, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[13] = mk(9'h004, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[14] = mk(9'h004, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[15] = mk(9'h000, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[16] = mk(9'h000, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);
    tbl[17] = mk(9'h000, 9'h1FB, 9'h000, 9'h000, 9'h000, '0);

    // Reset with every source high.
    rst = 1'b1;
    src_irq = '1; src_en = '1; src_edge = '0; pend_clr = '0;
    s4_irq = '1;  s4_en = '1;  s4_edge = '0;  s4_clr = '0;
    step(); step();
    chk("rst_out",   64'(irq_out), 64'h0);
    chk("rst_pend",  64'(pend_o),  64'h0);
    chk("rst_s4out", 64'(s4_out),  64'h0);
    chk("rst_s4pnd", 64'(s4_pend), 64'h0);
    rst = 1'b0;
    step(); chk("rel_e1", 64'(irq_out), 64'h0);
    step(); chk("rel_e2", 64'(irq_out), 64'h0);
    step(); chk("rel_e3", 64'(irq_out), 64'(FULL));
    chk("s4_rel_e3", 64'(s4_out), 64'h0);
    step(); chk("s4_rel_e4", 64'(s4_out), 64'h030F);
    chk("rel_e4", 64'(irq_out), 64'(FULL));

    // Drop all default sources and source 1 of the small instance.
    src_irq = '0; s4_irq = 4'hD;
    step(); step(); step();
    chk("fall_e3", 64'(irq_out), 64'h0);
    chk("s4_fall_e3", 64'(s4_out), 64'h030F);
    step();
    chk("s4_fall_e4", 64'(s4_out), 64'h010D);

    // Table-driven level-mode sequence.
    for (int i = 0; i < 18; i++) begin
      src_irq = tbl[i].irq; src_en = tbl[i].en;
      src_edge = tbl[i].edg; pend_clr = tbl[i].clr;
      step();
      chk($sformatf("lvl[%0d].out", i), 64'(irq_out), 64'(tbl[i].exp_out));
      chk($sformatf("lvl[%0d].pend", i), 64'(pend_o), 64'(tbl[i].exp_pend));
    end

    // Edge mode on source 7 (not mirrored).
    src_en = 9'h1FF; src_edge = 9'h080; src_irq = 9'h080;
    step(); chk("e7_e1_pend", 64'(pend_o), 64'h0);
    step(); chk("e7_e2_pend", 64'(pend_o), 64'h0);
    src_irq = 9'h000;
    step(); chk("e7_e3_pend", 64'(pend_o), 64'h080);
    chk("e7_e3_out", 64'(irq_out), 64'h0);
    step(); chk("e7_e4_out", 64'(irq_out), 64'h080);
    step(); step();
    chk("e7_hold_pend", 64'(pend_o), 64'h080);
    chk("e7_hold_out", 64'(irq_out), 64'h080);
    pend_clr = 9'h080;
    step(); chk("e7_clr_pend", 64'(pend_o), 64'h0);
    chk("e7_clr_out", 64'(irq_out), 64'h080);
    pend_clr = 9'h000;
    step(); chk("e7_clr_out1", 64'(irq_out), 64'h0);

    // Simultaneous rise and clear on source 0.
    src_edge = 9'h001; src_irq = 9'h001;
    step(); step();
    pend_clr = 9'h001;
    step(); chk("sc_pend", 64'(pend_o), 64'h001);
    pend_clr = 9'h000;
    step(); chk("sc_pend1", 64'(pend_o), 64'h001);
    chk("sc_out", 64'(irq_out), 64'h1_0000_0001);
    pend_clr = 9'h001;
    step(); chk("sc_clr_pend", 64'(pend_o), 64'h0);
    pend_clr = 9'h000;
    step(); chk("sc_clr_out", 64'(irq_out), 64'h0);

    // pend_clr on a level-mode source has no effect on its output.
    src_edge = 9'h000; pend_clr = 9'h001;
    step(); chk("lvclr_pend", 64'(pend_o), 64'h0);
    chk("lvclr_out", 64'(irq_out), 64'h1_0000_0001);
    pend_clr = 9'h000; src_irq = 9'h000;
    step(); step(); step(); step();
    chk("lvclr_idle", 64'(irq_out), 64'h0);

    // Enable drop discards pending on source 1.
    src_edge = 9'h002; src_irq = 9'h002;
    step(); step(); step();
    chk("en_pend", 64'(pend_o), 64'h002);
    step(); chk("en_out", 64'(irq_out), 64'h2_0000_0002);
    src_en = 9'h1FD;
    step(); chk("en_drop_pend", 64'(pend_o), 64'h0);
    chk("en_drop_out", 64'(irq_out), 64'h0);
    src_en = 9'h1FF;
    step(); chk("en_back_pend", 64'(pend_o), 64'h0);
    chk("en_back_out", 64'(irq_out), 64'h0);
    step(); chk("en_back_out1", 64'(irq_out), 64'h0);
    src_irq = 9'h000;

    // Asynchronous reset in the middle of a pending event.
    src_edge = 9'h080; src_irq = 9'h080;
    step(); step(); step(); step();
    chk("ar_pre_out", 64'(irq_out), 64'h080);
    #2 rst = 1'b1;
    #1;
    chk("ar_out", 64'(irq_out), 64'h0);
    chk("ar_pend", 64'(pend_o), 64'h0);
    src_irq = 9'h000;
    step(); rst = 1'b0;
    step(); step(); step(); step();
    chk("ar_post_out", 64'(irq_out), 64'h0);
    chk("ar_post_pend", 64'(pend_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
